// File: rtl/vx_dispatch_rx_pkg.sv
// vx_dispatch_rx_pkg: widths, dispatch packet and lane-batch payload types for vx_dispatch_rx.
// Lane batches are NUM_LANES wide; a full packet carries NUM_THREADS lanes.
package vx_dispatch_rx_pkg;

    localparam int XLEN        = 32;
    localparam int NUM_THREADS = 8;
    localparam int NUM_LANES   = 2;
    localparam int BATCH_CNT   = NUM_THREADS / NUM_LANES;
    localparam int UUID_W      = 44;
    localparam int ISSUE_WIS_W = 4;
    localparam int CU_WIS_W    = 2;
    localparam int NUM_REGS_W  = 5;
    localparam int NT_W        = $clog2(NUM_THREADS);
    localparam int OP_TYPE_W   = 4;

    function automatic int pid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PID_W = pid_w(BATCH_CNT);

    typedef struct packed {
        logic            use_imm;
        logic [XLEN-1:0] imm;
    } op_args_t;

    typedef struct packed {
        logic [UUID_W-1:0]                     uuid;
        logic [ISSUE_WIS_W-1:0]                wis;
        logic [NUM_THREADS-1:0]                tmask;
        logic [XLEN-1:0]                       pc;
        logic [OP_TYPE_W-1:0]                  op_type;
        op_args_t                              op_args;
        logic                                  wb;
        logic [NUM_REGS_W-1:0]                 rd;
        logic [NT_W-1:0]                       tid;
        logic [NUM_THREADS-1:0][XLEN-1:0]      rs1_data;
        logic [NUM_THREADS-1:0][XLEN-1:0]      rs2_data;
        logic [NUM_THREADS-1:0][XLEN-1:0]      rs3_data;
        logic [CU_WIS_W-1:0]                   cu_id;
    } dispatch_data_t;

    typedef struct packed {
        logic [UUID_W-1:0]                     uuid;
        logic [ISSUE_WIS_W-1:0]                wis;
        logic [NUM_LANES-1:0]                  tmask;
        logic [XLEN-1:0]                       pc;
        logic [OP_TYPE_W-1:0]                  op_type;
        op_args_t                              op_args;
        logic                                  wb;
        logic [NUM_REGS_W-1:0]                 rd;
        logic [NT_W-1:0]                       tid;
        logic [NUM_LANES-1:0][XLEN-1:0]        rs1_data;
        logic [NUM_LANES-1:0][XLEN-1:0]        rs2_data;
        logic [NUM_LANES-1:0][XLEN-1:0]        rs3_data;
        logic [CU_WIS_W-1:0]                   cu_id;
        logic [PID_W-1:0]                      pid;
        logic                                  sop;
        logic                                  eop;
    } dispatch_batch_t;

endpackage

// File: rtl/vx_dispatch_if.sv
// vx_dispatch_if: valid/ready handshake carrying one full dispatch packet.
interface vx_dispatch_if;
    import vx_dispatch_rx_pkg::*;

    logic           valid;
    dispatch_data_t data;
    logic           ready;

    modport master (output valid, data, input ready);
    modport slave  (input valid, data, output ready);

endinterface

// File: rtl/vx_batch_find.sv
// vx_batch_find: locates non-empty lane batches; first of the incoming packet,
// and first/next/last of the held packet relative to the current pid.
module vx_batch_find
    import vx_dispatch_rx_pkg::*;
(
    input  logic [NUM_THREADS-1:0] new_tmask,
    input  logic [NUM_THREADS-1:0] tmask,
    input  logic [PID_W-1:0]       pid,
    output logic [PID_W-1:0]       first_new,
    output logic [PID_W-1:0]       first_pid,
    output logic [PID_W-1:0]       next_pid,
    output logic [PID_W-1:0]       last_pid
);
    logic [BATCH_CNT-1:0] nz, new_nz;

    for (genvar g = 0; g < BATCH_CNT; g++) begin : g_nz
        assign nz[g]     = |tmask[g*NUM_LANES +: NUM_LANES];
        assign new_nz[g] = |new_tmask[g*NUM_LANES +: NUM_LANES];
    end

    // An all-zero mask resolves to pid 0 everywhere, giving a single sop/eop beat.
    always_comb begin
        first_new = '0;
        first_pid = '0;
        next_pid  = pid;
        last_pid  = '0;
        for (int i = BATCH_CNT - 1; i >= 0; i--) begin
            if (new_nz[i]) first_new = PID_W'(i);
            if (nz[i]) first_pid = PID_W'(i);
            if (nz[i] && i > int'(pid)) next_pid = PID_W'(i);
        end
        for (int i = 0; i < BATCH_CNT; i++)
            if (nz[i]) last_pid = PID_W'(i);
    end

endmodule

// File: rtl/vx_dispatch_rx.sv
// vx_dispatch_rx: slave end of the dispatch interface; replays each packet as lane batches.
// DISPATCH_RX_SKIP_EMPTY_EN defined: batches with an all-zero tmask slice are skipped.
module vx_dispatch_rx
    import vx_dispatch_rx_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    vx_dispatch_if.slave    dispatch_in,
    output logic            out_valid,
    output dispatch_batch_t out_data,
    input  logic            out_ready
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SPLIT = 1'b1;

    logic [0:0]       state;
    logic [PID_W-1:0] pid, first_new, first_pid, next_pid, last_pid;
    logic             is_last, accept;
    dispatch_data_t   payload;

`ifdef DISPATCH_RX_SKIP_EMPTY_EN
    vx_batch_find u_find (
        .new_tmask (dispatch_in.data.tmask),
        .tmask     (payload.tmask),
        .pid       (pid),
        .first_new (first_new),
        .first_pid (first_pid),
        .next_pid  (next_pid),
        .last_pid  (last_pid)
    );
`else
    assign first_new = '0;
    assign first_pid = '0;
    assign next_pid  = pid + PID_W'(1);
    assign last_pid  = PID_W'(BATCH_CNT - 1);
`endif

    assign is_last   = (pid == last_pid);
    assign out_valid = (state == SPLIT);
    // Accepting during the eop beat keeps packets back to back with no bubble.
    assign dispatch_in.ready = reset_n & ((state == IDLE) | (out_ready & is_last));
    assign accept    = dispatch_in.valid & dispatch_in.ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            pid   <= '0;
        end else if (accept) begin
            state <= SPLIT;
            pid   <= first_new;
        end else if (state == SPLIT && out_ready) begin
            state <= is_last ? IDLE : SPLIT;
            pid   <= is_last ? pid : next_pid;
        end
    end

    always_ff @(posedge clk)
        if (accept) payload <= dispatch_in.data;

    always_comb begin
        out_data.uuid     = payload.uuid;
        out_data.wis      = payload.wis;
        out_data.tmask    = payload.tmask[pid*NUM_LANES +: NUM_LANES];
        out_data.pc       = payload.pc;
        out_data.op_type  = payload.op_type;
        out_data.op_args  = payload.op_args;
        out_data.wb       = payload.wb;
        out_data.rd       = payload.rd;
        out_data.tid      = payload.tid;
        out_data.rs1_data = payload.rs1_data[pid*NUM_LANES +: NUM_LANES];
        out_data.rs2_data = payload.rs2_data[pid*NUM_LANES +: NUM_LANES];
        out_data.rs3_data = payload.rs3_data[pid*NUM_LANES +: NUM_LANES];
        out_data.cu_id    = payload.cu_id;
        out_data.pid      = pid;
        out_data.sop      = (pid == first_pid);
        out_data.eop      = is_last;
    end

endmodule

// File: tb/tb_vx_dispatch_rx.sv
// tb_vx_dispatch_rx: directed scenarios for vx_dispatch_rx (NUM_THREADS=8, NUM_LANES=2).
// Expectations follow DISPATCH_RX_SKIP_EMPTY_EN when it is defined for the build.
module tb_vx_dispatch_rx;
    import vx_dispatch_rx_pkg::*;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            out_ready = 1'b1;
    logic            out_valid;
    dispatch_batch_t out_data;
    int              n_cmp = 0;
    int              n_err = 0;

    vx_dispatch_if dif ();

    vx_dispatch_rx dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .dispatch_in (dif),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    function automatic dispatch_data_t mk(input logic [7:0] id, input logic [7:0] tm);
        dispatch_data_t p;
        p         = '0;
        p.uuid    = UUID_W'(id);
        p.wis     = 4'h3;
        p.tmask   = tm;
        p.pc      = {24'h800000, id};
        p.op_type = 4'h5;
        p.rd      = 5'd7;
        p.cu_id   = 2'd1;
        for (int t = 0; t < NUM_THREADS; t++) begin
            p.rs1_data[t] = {8'h10, 8'h00, id, 8'(t)};
            p.rs2_data[t] = {8'h20, 8'h00, id, 8'(t)};
            p.rs3_data[t] = {8'h30, 8'h00, id, 8'(t)};
        end
        return p;
    endfunction

    // Handshake only; returns at the negedge where the first beat is on the output.
    task automatic send(input dispatch_data_t p);
        int n;
        @(negedge clk);
        dif.valid = 1'b1;
        dif.data  = p;
        #1;
        n = 0;
        while (dif.ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (dif.ready !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: ready=%b required 1", dif.ready);
        end
        @(negedge clk);
        dif.valid = 1'b0;
    endtask

    task automatic test_reset;
        dif.valid = 1'b1;
        dif.data  = mk(8'hEE, 8'hFF);
        @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || dif.ready !== 1'b0 || out_data.pid !== '0) begin
            n_err++;
            $display("FAIL reset_hold: valid=%b ready=%b pid=%0d required 0 0 0", out_valid, dif.ready, out_data.pid);
        end
        dif.valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || dif.ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: valid=%b ready=%b required 0 1", out_valid, dif.ready);
        end
    endtask

    task automatic test_full_rate;
        send(mk(8'd1, 8'hFF));
        for (int p = 0; p < 4; p++) begin
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_data.pid !== PID_W'(p) || out_data.sop !== (p == 0) ||
                out_data.eop !== (p == 3) || out_data.tmask !== 2'b11 || dif.ready !== (p == 3) ||
                out_data.rs1_data[1] !== {8'h10, 8'h00, 8'd1, 8'(2*p+1)} || out_data.pc !== 32'h80000001) begin
                n_err++;
                $display("FAIL full_beat%0d: v=%b pid=%0d sop=%b eop=%b tm=%b rdy=%b rs1[1]=%h pc=%h required 1 %0d %b %b 11 %b %h 80000001",
                         p, out_valid, out_data.pid, out_data.sop, out_data.eop, out_data.tmask, dif.ready,
                         out_data.rs1_data[1], out_data.pc, p, p == 0, p == 3, p == 3, {8'h10, 8'h00, 8'd1, 8'(2*p+1)});
            end
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL full_idle: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        dif.valid = 1'b1;
        dif.data  = mk(8'd2, 8'hFF);
        #1;
        n_cmp++;
        if (dif.ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_accept_a: ready=%b required 1", dif.ready);
        end
        @(negedge clk);
        dif.data = mk(8'd3, 8'hFF);
        for (int p = 0; p < 4; p++) begin
            #1;
            n_cmp++;
            if (out_data.uuid !== UUID_W'(2) || out_data.pid !== PID_W'(p) || dif.ready !== (p == 3)) begin
                n_err++;
                $display("FAIL b2b_a%0d: uuid=%0d pid=%0d ready=%b required 2 %0d %b", p, out_data.uuid, out_data.pid, dif.ready, p, p == 3);
            end
            @(negedge clk);
        end
        dif.valid = 1'b0;
        for (int p = 0; p < 4; p++) begin
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_data.uuid !== UUID_W'(3) || out_data.pid !== PID_W'(p) || out_data.sop !== (p == 0)) begin
                n_err++;
                $display("FAIL b2b_b%0d: v=%b uuid=%0d pid=%0d sop=%b required 1 3 %0d %b", p, out_valid, out_data.uuid, out_data.pid, out_data.sop, p, p == 0);
            end
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_empty_batches;
        logic [7:0] tm;
        logic [1:0] ep [4];
        logic [1:0] et [4];
        int         n;
        for (int k = 0; k < 2; k++) begin
            tm = (k == 0) ? 8'b0011_0000 : 8'h00;
`ifdef DISPATCH_RX_SKIP_EMPTY_EN
            n  = 1;
            ep = (k == 0) ? '{2'd2, 2'd0, 2'd0, 2'd0} : '{2'd0, 2'd0, 2'd0, 2'd0};
            et = (k == 0) ? '{2'b11, 2'b00, 2'b00, 2'b00} : '{2'b00, 2'b00, 2'b00, 2'b00};
`else
            n  = 4;
            ep = '{2'd0, 2'd1, 2'd2, 2'd3};
            et = (k == 0) ? '{2'b00, 2'b00, 2'b11, 2'b00} : '{2'b00, 2'b00, 2'b00, 2'b00};
`endif
            send(mk(8'(4 + k), tm));
            for (int i = 0; i < n; i++) begin
                #1;
                n_cmp++;
                if (out_valid !== 1'b1 || out_data.pid !== ep[i] || out_data.sop !== (i == 0) ||
                    out_data.eop !== (i == n - 1) || out_data.tmask !== et[i]) begin
                    n_err++;
                    $display("FAIL empty%0d_beat%0d: v=%b pid=%0d sop=%b eop=%b tm=%b required 1 %0d %b %b %b",
                             k, i, out_valid, out_data.pid, out_data.sop, out_data.eop, out_data.tmask,
                             ep[i], i == 0, i == n - 1, et[i]);
                end
                @(negedge clk);
            end
            #1;
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL empty%0d_idle: valid=%b required 0", k, out_valid);
            end
        end
    endtask

    task automatic test_stall;
        send(mk(8'd6, 8'hFF));
        @(negedge clk);
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_data.pid !== PID_W'(1) || dif.ready !== 1'b0 ||
                out_data.rs1_data[0] !== {8'h10, 8'h00, 8'd6, 8'd2}) begin
                n_err++;
                $display("FAIL stall_pid1_%0d: v=%b pid=%0d ready=%b rs1[0]=%h required 1 1 0 10000602", s, out_valid, out_data.pid, dif.ready, out_data.rs1_data[0]);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (out_data.pid !== PID_W'(2) || out_data.sop !== 1'b0) begin
            n_err++;
            $display("FAIL stall_pid2: pid=%0d sop=%b required 2 0", out_data.pid, out_data.sop);
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        n_cmp++;
        if (out_data.pid !== PID_W'(3) || out_data.eop !== 1'b1 || dif.ready !== 1'b0) begin
            n_err++;
            $display("FAIL stall_eop_hold: pid=%0d eop=%b ready=%b required 3 1 0", out_data.pid, out_data.eop, dif.ready);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data.pid !== PID_W'(3) || dif.ready !== 1'b1) begin
            n_err++;
            $display("FAIL stall_eop_go: v=%b pid=%0d ready=%b required 1 3 1", out_valid, out_data.pid, dif.ready);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_idle: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid;
        send(mk(8'd7, 8'hFF));
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (out_data.pid !== PID_W'(2) || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_pre: pid=%0d v=%b required 2 1", out_data.pid, out_valid);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || dif.ready !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_async: v=%b ready=%b required 0 0", out_valid, dif.ready);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || dif.ready !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_release: v=%b ready=%b required 0 1", out_valid, dif.ready);
        end
        send(mk(8'd8, 8'hFF));
        for (int p = 0; p < 4; p++) begin
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_data.uuid !== UUID_W'(8) || out_data.pid !== PID_W'(p) || out_data.sop !== (p == 0)) begin
                n_err++;
                $display("FAIL rstmid_next%0d: v=%b uuid=%0d pid=%0d sop=%b required 1 8 %0d %b", p, out_valid, out_data.uuid, out_data.pid, out_data.sop, p, p == 0);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        dif.valid = 1'b0;
        dif.data  = mk(8'd0, 8'h00);
        test_reset();
        test_full_rate();
        test_back_to_back();
        test_empty_batches();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
